prt_scaler_lib_fifo_sc_fwft: RTL
================================

// Module: prt_scaler_lib_fifo_sc_fwft
//
// PURPOSE
// Parametrised single-clock FIFO, next generation of the scaler library FIFO. Adds a selectable
// first-word-fall-through (FWFT) read mode, true full capacity (all 2**P_ADR_WIDTH words usable),
// programmable almost-empty/almost-full flags and sticky overflow/underflow error flags.
// Used as line/pixel buffering between scaler pipeline stages in a single clock domain.
//
// PARAMETERS
// P_MODE       "std"          "std": registered read, 1-cycle latency; "fwft": head word presented on DAT_OUT
// P_RAM_STYLE  "distributed"  "distributed" or "block"; passed to RAM sub-module as synthesis attribute
// P_ADR_WIDTH  7              RAM address width; depth D = 2**P_ADR_WIDTH
// P_DAT_WIDTH  32             data width
// P_AE_LVL     4              AE_OUT asserted when occupancy <= P_AE_LVL (range 0..D)
// P_AF_LVL     D-4            AF_OUT asserted when occupancy >= P_AF_LVL (range 0..D)
//
// PORTS
// RST_IN    in   1              reset, asynchronous, active-high
// CLK_IN    in   1              clock (single clock domain)
// CLR_IN    in   1              synchronous clear of pointers, occupancy, pipeline and sticky flags
// WR_IN     in   1              write request
// DAT_IN    in   P_DAT_WIDTH    write data
// RD_IN     in   1              std: read request; fwft: acknowledge/pop of word on DAT_OUT
// DAT_OUT   out  P_DAT_WIDTH    read data (registered)
// DE_OUT    out  1              std: 1-cycle pulse, DAT_OUT valid; fwft: level, DAT_OUT holds head word
// WRDS_OUT  out  P_ADR_WIDTH+1  occupancy, 0..D
// EP_OUT    out  1              empty
// FL_OUT    out  1              full (occupancy == D)
// AE_OUT    out  1              almost empty
// AF_OUT    out  1              almost full
// OVF_OUT   out  1              sticky: write attempted while full
// UDF_OUT   out  1              sticky: read attempted while empty
//
// BEHAVIOUR
// - Reset (async) and CLR_IN (sync) give: DAT_OUT=0, DE_OUT=0, WRDS_OUT=0, EP_OUT=1, FL_OUT=0,
//   AE_OUT=1, AF_OUT=(P_AF_LVL==0), OVF_OUT=0, UDF_OUT=0. CLR_IN has priority over WR_IN/RD_IN in
//   the same cycle (both ignored); in-flight RAM reads are discarded, no DE_OUT follows a clear.
// - Pointers wp/rp are P_ADR_WIDTH+1 bits and wrap modulo 2*D; RAM address = low P_ADR_WIDTH bits.
// - Occupancy counter occ (P_ADR_WIDTH+1 bits) is the single source for WRDS_OUT/FL/AE/AF; all flags
//   registered, updated on the same edge as occ. occ +1 on accepted write, -1 on accepted read,
//   unchanged when both in one cycle.
// - Write accepted iff WR_IN && !FL_OUT; data stored at wp, wp+1. WR_IN && FL_OUT: dropped, OVF_OUT
//   set next cycle. Full + simultaneous read: write still rejected (FL_OUT is registered).
// - std mode: read accepted iff RD_IN && !EP_OUT; rp+1; DAT_OUT valid with DE_OUT=1 exactly one
//   cycle later. RD_IN && EP_OUT: DE_OUT stays 0, UDF_OUT set. EP_OUT = (occ==0). Empty + simultaneous
//   write: write accepted, read rejected, UDF_OUT set. DAT_OUT holds last value when DE_OUT=0.
// - fwft mode: internal prefetch issues RAM reads (1-cycle RAM latency) into a 2-entry skid feeding
//   the DAT_OUT register. Word written in cycle n into empty FIFO appears with DE_OUT=1 in cycle n+3.
//   Read accepted iff RD_IN && DE_OUT; next word presented the following cycle, so RD_IN held high
//   sustains 1 word/cycle with no bubbles. RD_IN && !DE_OUT: ignored, UDF_OUT set.
//   EP_OUT = !DE_OUT. occ counts all words held (RAM + in-flight + skid + DAT_OUT), capacity D total.
// - Word ordering strictly FIFO in both modes, across pointer wrap-around.
// - Flags AE/AF compare occ against parameters with unsigned compare at P_ADR_WIDTH+1 bits.
//
// STRUCTURE
// - Shared package prt_scaler_lib_pkg: mode string constants (P_MODE_STD, P_MODE_FWFT) and
//   function for default P_AF_LVL; no typedefs needed beyond these.
// - One sub-module: prt_scaler_lib_sdp_ram_sc (behavioural simple-dual-port RAM, one clock,
//   registered 1-cycle read, P_RAM_STYLE attribute). Pointer/flag logic and fwft prefetch/skid in top.
// - Generate on P_MODE selects std read path or fwft prefetch path.
//
// TESTING (P_ADR_WIDTH=4, D=16, P_DAT_WIDTH=16, P_AE_LVL=2, P_AF_LVL=14)
// 1 std: write 0x0001..0x0010 (16 words) -> FL_OUT=1, WRDS_OUT=16, AF_OUT=1; 17th write 0xDEAD ->
//   dropped, OVF_OUT=1; 16 reads -> DE_OUT pulses, data 0x0001..0x0010 in order, EP_OUT=1.
// 2 std: read on empty -> DE_OUT=0, UDF_OUT=1; CLR_IN -> UDF_OUT=0, all outputs at reset values.
// 3 fwft: single write 0x00A5 at cycle n -> DE_OUT=1, DAT_OUT=0x00A5 at n+3; RD_IN one cycle ->
//   DE_OUT=0, EP_OUT=1, WRDS_OUT=0.
// 4 fwft: fill 16, then RD_IN and WR_IN held high 100 cycles (incrementing data) -> one word per cycle
//   out, no gaps, no data loss, WRDS_OUT stays 15/16, ordering preserved across 6 pointer wraps.
// 5 both modes: random WR_IN/RD_IN (50%/50%, 10k cycles) vs scoreboard model -> data, WRDS_OUT,
//   AE/AF/FL/EP match every cycle; assert RST_IN mid-burst -> outputs reset immediately, async.

Source files
------------

// File: rtl/prt_scaler_lib_pkg.sv
// Shared constants for the scaler library FIFOs.
package prt_scaler_lib_pkg;

    localparam string P_MODE_STD  = "std";
    localparam string P_MODE_FWFT = "fwft";

    // Default almost-full level: four words below the full depth.
    function automatic int af_lvl_default(input int adr_width);
        return (1 << adr_width) - 4;
    endfunction

endpackage

// File: rtl/prt_scaler_lib_sdp_ram_sc.sv
// Simple dual-port RAM, one clock, registered read port with reset/clear.
module prt_scaler_lib_sdp_ram_sc #(
    parameter string P_RAM_STYLE = "distributed",
    parameter int    P_ADR_WIDTH = 7,
    parameter int    P_DAT_WIDTH = 32
) (
    input  logic                   RST_IN,
    input  logic                   CLK_IN,
    input  logic                   CLR_IN,
    input  logic                   WR_IN,
    input  logic [P_ADR_WIDTH-1:0] WADR_IN,
    input  logic [P_DAT_WIDTH-1:0] WDAT_IN,
    input  logic                   RD_IN,
    input  logic [P_ADR_WIDTH-1:0] RADR_IN,
    output logic [P_DAT_WIDTH-1:0] RDAT_OUT
);

    logic [P_DAT_WIDTH-1:0] mem_rd;

    if (P_RAM_STYLE == "block") begin : g_block
        (* ram_style = "block" *) logic [P_DAT_WIDTH-1:0] mem [2**P_ADR_WIDTH];
        // Write port
        always_ff @(posedge CLK_IN) begin
            if (WR_IN) mem[WADR_IN] <= WDAT_IN;
        end
        assign mem_rd = mem[RADR_IN];
    end else begin : g_dist
        (* ram_style = "distributed" *) logic [P_DAT_WIDTH-1:0] mem [2**P_ADR_WIDTH];
        // Write port
        always_ff @(posedge CLK_IN) begin
            if (WR_IN) mem[WADR_IN] <= WDAT_IN;
        end
        assign mem_rd = mem[RADR_IN];
    end

    // Registered read; holds its value when no read is issued
    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN)      RDAT_OUT <= '0;
        else if (CLR_IN) RDAT_OUT <= '0;
        else if (RD_IN)  RDAT_OUT <= mem_rd;
    end

endmodule

// File: rtl/prt_scaler_lib_fifo_sc_fwft.sv
// Single-clock FIFO with standard (registered read) or first-word-fall-through read mode.
module prt_scaler_lib_fifo_sc_fwft
    import prt_scaler_lib_pkg::*;
#(
    parameter string P_MODE      = P_MODE_STD,
    parameter string P_RAM_STYLE = "distributed",
    parameter int    P_ADR_WIDTH = 7,
    parameter int    P_DAT_WIDTH = 32,
    parameter int    P_AE_LVL    = 4,
    parameter int    P_AF_LVL    = af_lvl_default(P_ADR_WIDTH)
) (
    input  logic                   RST_IN,
    input  logic                   CLK_IN,
    input  logic                   CLR_IN,
    input  logic                   WR_IN,
    input  logic [P_DAT_WIDTH-1:0] DAT_IN,
    input  logic                   RD_IN,
    output logic [P_DAT_WIDTH-1:0] DAT_OUT,
    output logic                   DE_OUT,
    output logic [P_ADR_WIDTH:0]   WRDS_OUT,
    output logic                   EP_OUT,
    output logic                   FL_OUT,
    output logic                   AE_OUT,
    output logic                   AF_OUT,
    output logic                   OVF_OUT,
    output logic                   UDF_OUT
);

    localparam int                 D      = 1 << P_ADR_WIDTH;
    localparam logic [P_ADR_WIDTH:0] DEPTH  = D[P_ADR_WIDTH:0];
    localparam logic [P_ADR_WIDTH:0] AE_LVL = P_AE_LVL[P_ADR_WIDTH:0];
    localparam logic [P_ADR_WIDTH:0] AF_LVL = P_AF_LVL[P_ADR_WIDTH:0];
    localparam logic [P_ADR_WIDTH:0] ONE    = 1;
    localparam logic                 AF_RST = (P_AF_LVL == 0);

    logic [P_ADR_WIDTH:0]   wp, rp, occ, occ_nxt;
    logic                   wr_acc, rd_acc, ram_re, udf_evt;
    logic                   fl_r, ae_r, af_r, ovf_r, udf_r;
    logic [P_DAT_WIDTH-1:0] ram_q;

    // Full flag is registered, so a read in the same cycle cannot make room for a write
    assign wr_acc = WR_IN && !fl_r && !CLR_IN;

    prt_scaler_lib_sdp_ram_sc #(
        .P_RAM_STYLE (P_RAM_STYLE),
        .P_ADR_WIDTH (P_ADR_WIDTH),
        .P_DAT_WIDTH (P_DAT_WIDTH)
    ) u_ram (
        .RST_IN   (RST_IN),
        .CLK_IN   (CLK_IN),
        .CLR_IN   (CLR_IN),
        .WR_IN    (wr_acc),
        .WADR_IN  (wp[P_ADR_WIDTH-1:0]),
        .WDAT_IN  (DAT_IN),
        .RD_IN    (ram_re),
        .RADR_IN  (rp[P_ADR_WIDTH-1:0]),
        .RDAT_OUT (ram_q)
    );

    // Occupancy update: counts every word held, wherever it sits
    always_comb begin
        occ_nxt = occ;
        case ({wr_acc, rd_acc})
            2'b10:   occ_nxt = occ + ONE;
            2'b01:   occ_nxt = occ - ONE;
            default: occ_nxt = occ;
        endcase
    end

    // Pointers, occupancy and flags; flags follow occ on the same edge
    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            wp <= '0; rp <= '0; occ <= '0;
            fl_r <= 1'b0; ae_r <= 1'b1; af_r <= AF_RST; ovf_r <= 1'b0; udf_r <= 1'b0;
        end else if (CLR_IN) begin
            wp <= '0; rp <= '0; occ <= '0;
            fl_r <= 1'b0; ae_r <= 1'b1; af_r <= AF_RST; ovf_r <= 1'b0; udf_r <= 1'b0;
        end else begin
            if (wr_acc) wp <= wp + ONE;
            if (ram_re) rp <= rp + ONE;
            occ  <= occ_nxt;
            fl_r <= (occ_nxt == DEPTH);
            ae_r <= (occ_nxt <= AE_LVL);
            af_r <= (occ_nxt >= AF_LVL);
            if (WR_IN && fl_r) ovf_r <= 1'b1;
            if (udf_evt)       udf_r <= 1'b1;
        end
    end

    if (P_MODE == P_MODE_FWFT) begin : g_fwft
        logic [P_DAT_WIDTH-1:0] skid [2];
        logic [P_DAT_WIDTH-1:0] dat_r;
        logic [1:0]             skid_cnt, pipe_cnt;
        logic                   ram_vld, de_r, ld_out, ld_skid, push_skid;

        assign rd_acc   = RD_IN && de_r && !CLR_IN;
        assign udf_evt  = RD_IN && !de_r;
        // Words past the RAM: in-flight read, skid entries and the output register (max 3)
        assign pipe_cnt = {1'b0, ram_vld} + skid_cnt + {1'b0, de_r};
        // Prefetch whenever the downstream slots can absorb one more word after this cycle's pop
        assign ram_re   = !CLR_IN && ((wp - rp) != '0) && ((pipe_cnt - {1'b0, rd_acc}) <= 2'd2);
        assign ld_out   = !de_r || rd_acc;
        // Skid holds older words than the RAM output, so it drains first
        assign ld_skid  = ld_out && (skid_cnt != 2'd0);
        assign push_skid = ram_vld && !(ld_out && (skid_cnt == 2'd0));

        // Output register, skid occupancy and in-flight read tracking
        always_ff @(posedge CLK_IN or posedge RST_IN) begin
            if (RST_IN) begin
                ram_vld <= 1'b0; skid_cnt <= 2'd0; de_r <= 1'b0; dat_r <= '0;
            end else if (CLR_IN) begin
                ram_vld <= 1'b0; skid_cnt <= 2'd0; de_r <= 1'b0; dat_r <= '0;
            end else begin
                ram_vld <= ram_re;
                if (ld_out) begin
                    if (skid_cnt != 2'd0) begin
                        dat_r <= skid[0];
                        de_r  <= 1'b1;
                    end else if (ram_vld) begin
                        dat_r <= ram_q;
                        de_r  <= 1'b1;
                    end else begin
                        de_r  <= 1'b0;
                    end
                end
                if (ld_skid && !push_skid)      skid_cnt <= skid_cnt - 2'd1;
                else if (!ld_skid && push_skid) skid_cnt <= skid_cnt + 2'd1;
            end
        end

        // Skid data; entry 0 is always the oldest word
        always_ff @(posedge CLK_IN) begin
            if (ld_skid && push_skid) begin
                if (skid_cnt == 2'd1) skid[0] <= ram_q;
                else begin
                    skid[0] <= skid[1];
                    skid[1] <= ram_q;
                end
            end else if (ld_skid) begin
                skid[0] <= skid[1];
            end else if (push_skid) begin
                if (skid_cnt == 2'd0) skid[0] <= ram_q;
                else                  skid[1] <= ram_q;
            end
        end

        assign DAT_OUT = dat_r;
        assign DE_OUT  = de_r;
        assign EP_OUT  = !de_r;
    end else begin : g_std
        logic ep_r, de_r;

        assign rd_acc  = RD_IN && !ep_r && !CLR_IN;
        assign ram_re  = rd_acc;
        assign udf_evt = RD_IN && ep_r;

        // Empty flag and one-cycle data-valid pulse
        always_ff @(posedge CLK_IN or posedge RST_IN) begin
            if (RST_IN) begin
                ep_r <= 1'b1; de_r <= 1'b0;
            end else if (CLR_IN) begin
                ep_r <= 1'b1; de_r <= 1'b0;
            end else begin
                ep_r <= (occ_nxt == '0);
                de_r <= rd_acc;
            end
        end

        assign DAT_OUT = ram_q;
        assign DE_OUT  = de_r;
        assign EP_OUT  = ep_r;
    end

    assign WRDS_OUT = occ;
    assign FL_OUT   = fl_r;
    assign AE_OUT   = ae_r;
    assign AF_OUT   = af_r;
    assign OVF_OUT  = ovf_r;
    assign UDF_OUT  = udf_r;

endmodule
